// File: rtl/jump_unit.sv
// Branch-resolution unit: decodes the jump-control bits with the ALU zero
// flag into the PC-next mux select, and keeps a registered flush request
// plus a count of taken jumps.
module jump_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FlagZ,
  input  logic             JumpCD,
  input  logic             JumpCI,
  input  logic             JumpI,
  output logic             PCSource,
  output logic             FlushQ,
  output logic             IllegalJump,
  output logic [CNT_W-1:0] TakenCount
);

  logic             flushD;
  logic             flushQ;
  logic [CNT_W-1:0] takenCountD;
  logic [CNT_W-1:0] takenCountQ;

  // Jump decision and encoding check; no state, so valid during reset.
  // Overlapping bits still jump if any condition is satisfied.
  always_comb begin
    PCSource    = JumpI | (JumpCI & FlagZ) | (JumpCD & ~FlagZ);
    IllegalJump = (JumpI & JumpCI) | (JumpI & JumpCD) | (JumpCI & JumpCD);
  end

  // Next-state for the flush request and the wrapping taken-jump counter.
  always_comb begin
    flushD      = PCSource;
    takenCountD = takenCountQ;
    if (PCSource) begin
      takenCountD = takenCountQ + CNT_W'(1);
    end
  end

  // Synchronous reset wins over a jump taken in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      flushQ      <= 1'b0;
      takenCountQ <= '0;
    end else begin
      flushQ      <= flushD;
      takenCountQ <= takenCountD;
    end
  end

  assign FlushQ     = flushQ;
  assign TakenCount = takenCountQ;

endmodule

// File: tb/tb_jump_unit.sv
// Scoreboard bench for jump_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against a 16-bit and a 2-bit DUT.
module tb_jump_unit;

  logic        clk;
  logic        rst;
  logic        FlagZ;
  logic        JumpCD;
  logic        JumpCI;
  logic        JumpI;
  logic        PCSource;
  logic        FlushQ;
  logic        IllegalJump;
  logic [15:0] TakenCount;
  logic        PCSource2;
  logic        FlushQ2;
  logic        IllegalJump2;
  logic [1:0]  TakenCount2;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        pc;
    logic        ill;
    logic        fl;
    logic [15:0] cnt;
  } exp_t;

  exp_t expQ[$];

  jump_unit #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .FlagZ      (FlagZ),
    .JumpCD     (JumpCD),
    .JumpCI     (JumpCI),
    .JumpI      (JumpI),
    .PCSource   (PCSource),
    .FlushQ     (FlushQ),
    .IllegalJump(IllegalJump),
    .TakenCount (TakenCount)
  );

  jump_unit #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .FlagZ      (FlagZ),
    .JumpCD     (JumpCD),
    .JumpCI     (JumpCI),
    .JumpI      (JumpI),
    .PCSource   (PCSource2),
    .FlushQ     (FlushQ2),
    .IllegalJump(IllegalJump2),
    .TakenCount (TakenCount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  int monStep = 0;
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      logic [15:0] cnt2;
      e = expQ.pop_front();
      monStep++;
      cnt2 = {14'd0, e.cnt[1:0]};
      chk("PCSource",     monStep, {15'd0, PCSource},     {15'd0, e.pc});
      chk("IllegalJump",  monStep, {15'd0, IllegalJump},  {15'd0, e.ill});
      chk("FlushQ",       monStep, {15'd0, FlushQ},       {15'd0, e.fl});
      chk("TakenCount",   monStep, TakenCount,            e.cnt);
      chk("PCSource2",    monStep, {15'd0, PCSource2},    {15'd0, e.pc});
      chk("IllegalJump2", monStep, {15'd0, IllegalJump2}, {15'd0, e.ill});
      chk("FlushQ2",      monStep, {15'd0, FlushQ2},      {15'd0, e.fl});
      chk("TakenCount2",  monStep, {14'd0, TakenCount2},  cnt2);
    end
  end

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic step(input logic r, input logic ji, input logic jci, input logic jcd,
                      input logic z, input logic ePc, input logic eIll, input logic eFl,
                      input logic [15:0] eCnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    JumpI  = ji;
    JumpCI = jci;
    JumpCD = jcd;
    FlagZ  = z;
    e.pc  = ePc;
    e.ill = eIll;
    e.fl  = eFl;
    e.cnt = eCnt;
    expQ.push_back(e);
  endtask

  initial begin
    rst    = 1'b1;
    JumpI  = 1'b0;
    JumpCI = 1'b0;
    JumpCD = 1'b0;
    FlagZ  = 1'b0;
    repeat (2) @(posedge clk);

    //    rst JI JCI JCD Z   pc ill fl cnt
    // Reset state and no-jump instructions
    step(1, 0, 0, 0, 0,  0, 0, 0, 16'd0);
    step(0, 0, 0, 0, 0,  0, 0, 0, 16'd0);
    step(0, 0, 0, 0, 1,  0, 0, 0, 16'd0);
    // Unconditional jump, then flush on the following cycle
    step(0, 1, 0, 0, 0,  1, 0, 0, 16'd0);
    step(0, 1, 0, 0, 1,  1, 0, 1, 16'd1);
    step(0, 0, 0, 0, 0,  0, 0, 1, 16'd2);
    // Jump if equal
    step(0, 0, 1, 0, 0,  0, 0, 0, 16'd2);
    step(0, 0, 1, 0, 1,  1, 0, 0, 16'd2);
    // Jump if different
    step(0, 0, 0, 1, 0,  1, 0, 1, 16'd3);
    step(0, 0, 0, 1, 1,  0, 0, 1, 16'd4);
    // Reset held 3 cycles with JumpI, then 4 free cycles
    step(1, 1, 0, 0, 0,  1, 0, 0, 16'd4);
    step(1, 1, 0, 0, 0,  1, 0, 0, 16'd0);
    step(1, 1, 0, 0, 0,  1, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0,  1, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0,  1, 0, 1, 16'd1);
    step(0, 1, 0, 0, 0,  1, 0, 1, 16'd2);
    step(0, 1, 0, 0, 0,  1, 0, 1, 16'd3);
    step(0, 0, 0, 0, 0,  0, 0, 1, 16'd4);
    // Reset, then 5 jumps: 2-bit counter wraps to 1
    step(1, 0, 0, 0, 0,  0, 0, 0, 16'd4);
    step(0, 1, 0, 0, 0,  1, 0, 0, 16'd0);
    step(0, 1, 0, 0, 0,  1, 0, 1, 16'd1);
    step(0, 1, 0, 0, 0,  1, 0, 1, 16'd2);
    step(0, 1, 0, 0, 0,  1, 0, 1, 16'd3);
    step(0, 1, 0, 0, 0,  1, 0, 1, 16'd4);
    step(0, 0, 0, 0, 0,  0, 0, 1, 16'd5);
    // Illegal multi-bit encodings
    step(0, 0, 1, 1, 0,  1, 1, 0, 16'd5);
    step(0, 0, 1, 1, 1,  1, 1, 1, 16'd6);
    step(0, 1, 1, 1, 0,  1, 1, 1, 16'd7);
    step(0, 1, 0, 1, 1,  1, 1, 1, 16'd8);
    step(0, 0, 0, 0, 0,  0, 0, 1, 16'd9);

    // Let the monitor drain the queue; a leftover entry is a failure.
    repeat (3) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
